// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO read streamer: FSM state encoding and skid-buffer depth.
package fifo_pkg;

    localparam int unsigned SkidDepth = 2;

    typedef enum logic [1:0] {
        StIdle,
        StBurst,
        StDrain
    } rd_state_e;

endpackage

// File: rtl/fifo_skid_buf.sv
// Two-entry skid buffer with valid/ready on both sides; absorbs the FIFO's one-cycle
// read latency so the stream can be stalled without losing words already popped.
module fifo_skid_buf
    import fifo_pkg::*;
#(
    parameter int unsigned DataWidth = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [DataWidth-1:0] in_data_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [DataWidth-1:0] out_data_o,
    output logic [1:0]           level_o
);

    logic [DataWidth-1:0] mem_q [SkidDepth];
    logic [DataWidth-1:0] mem_d [SkidDepth];
    logic                 wr_ptr_q, wr_ptr_d;
    logic                 rd_ptr_q, rd_ptr_d;
    logic [1:0]           level_q, level_d;
    logic                 push, pop;

    assign out_valid_o = (level_q != 2'd0);
    assign out_data_o  = mem_q[rd_ptr_q];
    assign level_o     = level_q;
    assign pop         = out_valid_o && out_ready_i;
    // A slot vacated by this cycle's pop may be refilled in the same cycle.
    assign in_ready_o  = (level_q < 2'(SkidDepth)) || pop;
    assign push        = in_valid_i && in_ready_o;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            mem_d[wr_ptr_q] = in_data_i;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        level_d = level_q + 2'(push) - 2'(pop);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            level_q  <= 2'd0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

endmodule

// File: rtl/fifo_rd_streamer.sv
// Pops a requested number of words from a FIFO read port and presents them as a
// valid/ready stream, marking the final word and pulsing done when the burst completes.
module fifo_rd_streamer
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned LEN_WIDTH  = 8
) (
    input  logic                  rd_clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [LEN_WIDTH-1:0]  burst_len,
    input  logic                  fifo_empty,
    output logic                  fifo_rd_en,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last,
    output logic                  busy,
    output logic                  done
);

    rd_state_e            state_q, state_d;
    logic [LEN_WIDTH-1:0] issue_q, issue_d;
    logic [LEN_WIDTH-1:0] accept_q, accept_d;
    logic                 inflight_q;
    logic                 done_q, done_d;
    logic                 skid_in_ready;
    logic [1:0]           level;
    logic [1:0]           occupancy;
    logic                 hs;

    fifo_skid_buf #(
        .DataWidth (DATA_WIDTH)
    ) u_skid (
        .clk_i       (rd_clk),
        .rst_ni      (reset_n),
        .in_valid_i  (inflight_q),
        .in_ready_o  (skid_in_ready),
        .in_data_i   (fifo_rd_data),
        .out_valid_o (m_valid),
        .out_ready_i (m_ready),
        .out_data_o  (m_data),
        .level_o     (level)
    );

    assign hs = m_valid && m_ready;
    // Buffered words counted after this cycle's handshake, so a draining buffer keeps
    // issuing back-to-back and the stream sustains one word per cycle.
    assign occupancy  = level - 2'(hs) + 2'(inflight_q);
    assign fifo_rd_en = reset_n && (state_q == StBurst) && !fifo_empty
                        && (issue_q != '0) && (occupancy < 2'(SkidDepth)) && skid_in_ready;

    assign m_last = m_valid && (accept_q == LEN_WIDTH'(1));
    assign busy   = (state_q != StIdle);
    assign done   = done_q;

    always_comb begin
        state_d  = state_q;
        issue_d  = issue_q;
        accept_d = accept_q;
        done_d   = 1'b0;
        if (fifo_rd_en) begin
            issue_d = issue_q - LEN_WIDTH'(1);
        end
        if (hs && (state_q != StIdle)) begin
            accept_d = accept_q - LEN_WIDTH'(1);
        end
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    if (burst_len == '0) begin
                        done_d = 1'b1;
                    end else begin
                        issue_d  = burst_len;
                        accept_d = burst_len;
                        state_d  = StBurst;
                    end
                end
            end
            StBurst: begin
                if (issue_d == '0) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                if (hs && (accept_q == LEN_WIDTH'(1))) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge rd_clk) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            issue_q    <= '0;
            accept_q   <= '0;
            inflight_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            issue_q    <= issue_d;
            accept_q   <= accept_d;
            inflight_q <= fifo_rd_en;
            done_q     <= done_d;
        end
    end

endmodule

// File: tb/tb_fifo_rd_streamer.sv
// Self-checking bench: behavioural FIFO plus a word-order scoreboard and burst model.
module tb_fifo_rd_streamer;

    localparam int DW = 8;
    localparam int LW = 8;

    logic          rd_clk = 1'b0;
    logic          reset_n, start, fifo_empty, fifo_rd_en;
    logic          m_valid, m_ready, m_last, busy, done;
    logic [LW-1:0] burst_len;
    logic [DW-1:0] fifo_rd_data, m_data;

    logic [DW-1:0] fifo_q[$];
    logic [DW-1:0] ref_q[$];
    int            n_chk = 0, n_err = 0, cyc = 0;
    int            wr_pending = 0, ready_mode = 0;
    bit            mbusy = 0, mdone = 0, held = 0;
    int            len = 0, acc = 0, pops = 0, done_cnt = 0, first_hs = 0, last_hs = 0;
    logic [DW-1:0] held_data;

    fifo_rd_streamer #(
        .DATA_WIDTH (DW),
        .LEN_WIDTH  (LW)
    ) dut (
        .rd_clk       (rd_clk),
        .reset_n      (reset_n),
        .start        (start),
        .burst_len    (burst_len),
        .fifo_empty   (fifo_empty),
        .fifo_rd_en   (fifo_rd_en),
        .fifo_rd_data (fifo_rd_data),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .m_data       (m_data),
        .m_last       (m_last),
        .busy         (busy),
        .done         (done)
    );

    always #5 rd_clk = ~rd_clk;

    initial begin
        #1ms;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    task automatic push(input logic [DW-1:0] w);
        fifo_q.push_back(w);
        ref_q.push_back(w);
        fifo_empty = 1'b0;
    endtask

    // Burst model: what busy/done/m_last must be this cycle and which word comes next.
    task automatic monitor();
        bit idle_now;
        idle_now = !mbusy;
        chk("busy", 32'(busy), 32'(mbusy));
        chk("done", 32'(done), 32'(mdone));
        if (idle_now) begin
            chk("rd_en_idle", 32'(fifo_rd_en), 0);
            chk("valid_idle", 32'(m_valid), 0);
        end
        if (fifo_rd_en) chk("rd_on_empty", 32'(fifo_empty), 0);
        if (held) begin
            chk("hold_valid", 32'(m_valid), 1);
            chk("hold_data", 32'(m_data), 32'(held_data));
        end
        if (mbusy && m_valid) chk("last", 32'(m_last), 32'(acc + 1 == len));
        else chk("last_novalid", 32'(m_last), 0);
        mdone = 1'b0;
        if (!reset_n) begin
            // Words popped but not yet delivered are lost across reset.
            mbusy = 1'b0;
            held  = 1'b0;
            acc   = 0;
            ref_q = fifo_q;
            return;
        end
        held      = m_valid && !m_ready;
        held_data = m_data;
        if (fifo_rd_en) pops++;
        if (mbusy && m_valid && m_ready) begin
            if (acc == 0) first_hs = cyc;
            last_hs = cyc;
            if (ref_q.size() == 0) chk("spurious_word", 32'(m_valid), 0);
            else chk("data", 32'(m_data), 32'(ref_q.pop_front()));
            acc++;
            if (acc == len) begin
                mbusy = 1'b0;
                mdone = 1'b1;
                done_cnt++;
                chk("pop_count", pops, len);
            end
        end
        if (idle_now && start) begin
            if (burst_len == '0) begin
                mdone = 1'b1;
                done_cnt++;
            end else begin
                mbusy = 1'b1;
                len   = int'(burst_len);
                acc   = 0;
                pops  = 0;
            end
        end
    endtask

    task automatic cycle();
        bit pop;
        @(negedge rd_clk);
        monitor();
        pop = fifo_rd_en;
        @(posedge rd_clk);
        #1;
        cyc++;
        if (pop && fifo_q.size() > 0) fifo_rd_data = fifo_q.pop_front();
        if (wr_pending > 0 && $urandom_range(0, 3) != 0) begin
            push(DW'($urandom));
            wr_pending--;
        end
        fifo_empty = (fifo_q.size() == 0);
        case (ready_mode)
            0:       m_ready = 1'b1;
            1:       m_ready = ($urandom_range(0, 9) < 7);
            default: m_ready = 1'b0;
        endcase
    endtask

    task automatic start_burst(input int l);
        start     = 1'b1;
        burst_len = LW'(l);
        cycle();
        start     = 1'b0;
        burst_len = LW'($urandom);
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while ((mbusy || mdone) && n < budget) begin
            cycle();
            n++;
        end
        chk("idle_reached", 32'(busy), 0);
    endtask

    initial begin
        int d0, n, l, k;
        reset_n = 1'b0; start = 1'b0; burst_len = '0; m_ready = 1'b0;
        fifo_empty = 1'b1; fifo_rd_data = '0; ready_mode = 0;
        repeat (2) @(posedge rd_clk);
        #1;
        chk("rst_rd_en", 32'(fifo_rd_en), 0);
        chk("rst_valid", 32'(m_valid), 0);
        chk("rst_last", 32'(m_last), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_data", 32'(m_data), 0);
        reset_n = 1'b1;
        m_ready = 1'b1;
        cycle();

        // Back-to-back delivery with the stream always ready.
        push(8'hAA); push(8'hBB); push(8'hCC);
        d0 = done_cnt;
        start_burst(3);
        wait_idle(50);
        chk("t1_consecutive", last_hs - first_hs, 2);
        chk("t1_done_once", done_cnt - d0, 1);

        // Downstream stall: only two pops outstanding, head word held.
        push(8'hAA); push(8'hBB); push(8'hCC);
        ready_mode = 2; m_ready = 1'b0;
        start_burst(3);
        n = 0;
        while (!m_valid && n < 20) begin cycle(); n++; end
        chk("t2_valid_seen", 32'(m_valid), 1);
        repeat (5) cycle();
        chk("t2_pops_held", pops, 2);
        chk("t2_data_held", 32'(m_data), 32'hAA);
        ready_mode = 0; m_ready = 1'b1;
        wait_idle(50);

        // Empty FIFO at start; words trickle in later.
        d0 = done_cnt;
        start_burst(2);
        repeat (5) cycle();
        push(8'h11);
        repeat (6) cycle();
        chk("t3_busy_waiting", 32'(busy), 1);
        push(8'h22);
        wait_idle(50);
        chk("t3_done_once", done_cnt - d0, 1);

        // Zero-length request.
        d0 = done_cnt;
        start_burst(0);
        chk("t4_busy_zero", 32'(busy), 0);
        wait_idle(10);
        chk("t4_done_once", done_cnt - d0, 1);

        // Start while busy is ignored.
        push(8'h31); push(8'h32); push(8'h33);
        d0 = done_cnt;
        start_burst(3);
        repeat (2) cycle();
        start = 1'b1; burst_len = LW'(7);
        cycle();
        start = 1'b0;
        wait_idle(50);
        chk("t5_done_once", done_cnt - d0, 1);

        // Reset mid-burst, then a fresh burst returns the next FIFO words.
        for (int i = 0; i < 6; i++) push(DW'(8'h41 + i));
        start_burst(4);
        n = 0;
        while (acc < 2 && n < 20) begin cycle(); n++; end
        reset_n = 1'b0;
        cycle();
        reset_n = 1'b1;
        chk("t6_rd_en", 32'(fifo_rd_en), 0);
        chk("t6_valid", 32'(m_valid), 0);
        chk("t6_last", 32'(m_last), 0);
        chk("t6_busy", 32'(busy), 0);
        chk("t6_done", 32'(done), 0);
        chk("t6_data", 32'(m_data), 0);
        start_burst(2);
        wait_idle(50);
        chk("t6_fifo_drained", fifo_q.size(), 0);

        // Largest burst the counters allow, with random backpressure.
        for (int i = 0; i < 255; i++) push(DW'($urandom));
        ready_mode = 1;
        start_burst(255);
        wait_idle(3000);

        // Random bursts with random fill timing and backpressure.
        repeat (25) begin
            l = $urandom_range(0, 12);
            k = $urandom_range(0, l);
            for (int i = 0; i < k; i++) push(DW'($urandom));
            wr_pending = l - k + $urandom_range(0, 2);
            ready_mode = $urandom_range(0, 1);
            start_burst(l);
            wait_idle(500);
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/fifo_rd_streamer.md
FIFO_RD_STREAMER -- requirements
Module: fifo_rd_streamer

Interface
REQ-001 Parameter DATA_WIDTH, default 8, width of FIFO read data and stream data.
REQ-002 Parameter LEN_WIDTH, default 8, width of burst length and word counters.
REQ-003 rd_clk  input  1  sole clock; all logic on rising edge.
REQ-004 reset_n  input  1  synchronous, active-low reset, sampled on rd_clk.
REQ-005 start  input  1  one-cycle burst request, sampled in IDLE only.
REQ-006 burst_len  input  LEN_WIDTH  number of words to pop, captured with start.
REQ-007 fifo_empty  input  1  FIFO read-side empty flag.
REQ-008 fifo_rd_en  output  1  FIFO pop strobe.
REQ-009 fifo_rd_data  input  DATA_WIDTH  FIFO read data, valid the cycle after fifo_rd_en.
REQ-010 m_valid  output  1  stream word available.
REQ-011 m_ready  input  1  downstream accepts word when m_valid && m_ready.
REQ-012 m_data  output  DATA_WIDTH  stream word.
REQ-013 m_last  output  1  high with final word of burst.
REQ-014 busy  output  1  high in any state other than IDLE.
REQ-015 done  output  1  one-cycle pulse at burst completion.

Function
REQ-016 FSM states SHALL be IDLE, BURST, DRAIN.
REQ-017 IDLE -> BURST on start with burst_len != 0; burst_len captured into issue and accept counters.
REQ-018 start with burst_len == 0 SHALL issue no reads, stay in IDLE, and pulse done on the next cycle.
REQ-019 start while busy SHALL be ignored; burst_len is not re-sampled.
REQ-020 fifo_rd_en = (state == BURST) && !fifo_empty && issue_remaining != 0 && (words_buffered + reads_in_flight) < 2.
REQ-021 Data returned one cycle after fifo_rd_en SHALL be written into a 2-entry output skid buffer; no word is dropped or duplicated.
REQ-022 m_valid = buffer non-empty; m_data = oldest buffered word; order matches FIFO pop order.
REQ-023 m_valid and m_data SHALL hold stable while m_valid && !m_ready.
REQ-024 Simultaneous buffer write and stream handshake SHALL be supported, sustaining one word per cycle when m_ready stays high and FIFO is non-empty.
REQ-025 BURST -> DRAIN when issue_remaining reaches 0; DRAIN -> IDLE on the handshake of the last word.
REQ-026 m_last SHALL be high exactly when the word on m_data is the burst's final word (accept counter == 1).
REQ-027 done SHALL pulse one cycle after the last-word handshake; busy drops in that same cycle.
REQ-028 fifo_empty high in BURST SHALL stall issue without state change; the burst resumes when data arrives.
REQ-029 Counters SHALL be LEN_WIDTH bits; maximum burst is 2^LEN_WIDTH - 1 words; no wrap within a burst.

Reset
REQ-030 While reset_n == 0 at a rising edge: state = IDLE; counters, buffer, and in-flight flag cleared; outputs fifo_rd_en, m_valid, m_last, busy, done = 0; m_data = 0.
REQ-031 Reset mid-burst SHALL abort; any word in flight SHALL be discarded (it is lost from the FIFO); no done pulse.

Structure
REQ-032 Shared package fifo_pkg SHALL hold the FSM state encoding and the skid-buffer depth constant (2).
REQ-033 The 2-entry skid buffer SHALL be a sub-module, fifo_skid_buf, with valid/ready on both sides.

Verification
REQ-034 FIFO preloaded AA,BB,CC; start, burst_len=3, m_ready=1 -> m_data AA,BB,CC on consecutive cycles, m_last with CC, done one cycle later, fifo_rd_en high for exactly 3 cycles.
REQ-035 Same preload, m_ready held 0 for 5 cycles after the first m_valid -> exactly 2 pops issued, m_data holds AA stable; on release, AA,BB,CC are delivered with no loss.
REQ-036 FIFO empty at start, burst_len=2; write 11 at cycle 6 and 22 at cycle 12 -> busy stays high, outputs 11 then 22 (m_last on 22), done pulses once.
REQ-037 start with burst_len=0 -> no fifo_rd_en, busy stays 0, done pulses once on the next cycle.
REQ-038 reset_n low for 1 cycle after the second of 4 words -> all outputs 0 next cycle, state IDLE; a new burst_len=2 burst returns the next two FIFO words.
REQ-039 start pulsed again mid-burst with burst_len=7 -> ignored; original burst of 3 completes with one done.
